cycle_controller: RTL

CYCLE_CONTROLLER -- requirements
Module: cycle_controller

---
 rtl/cpu_pkg.sv | 18 +
 rtl/bus_wait_timer.sv | 42 ++++
 rtl/cycle_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller FSM states, bus phase encoding and
// common widths used by the cycle controller and its wait timer.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } cpu_state_e;

  // Phase reported to the PC unit on the `state` output.
  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_EXEC  = 1'b1;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts waitrequest cycles of the current bus access and raises a sticky
// bus error when an access has been stretched for WAIT_LIMIT cycles.
module bus_wait_timer
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic waitrequest,
  output logic timeout,
  output logic bus_error
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(WAIT_LIMIT);

  logic [WAIT_CNT_W-1:0] count;

  // Fires on the cycle whose waitrequest brings the count to LIMIT, so the
  // controller can leave the access on that very edge.
  assign timeout = busy && waitrequest && (count == LIMIT - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      bus_error <= 1'b0;
    end else begin
      if (!busy || !waitrequest) begin
        count <= '0;
      end else if (count != LIMIT) begin
        count <= count + 1'b1;
      end
      if (timeout) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cycle_controller.sv
// Multi-cycle CPU bus sequencer: alternates instruction fetch and execute
// phases on a waitrequest-style memory bus, halting on stop or timeout.
module cycle_controller
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] pc_addr,
  input  logic [31:0] data_addr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [3:0]  store_be,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        state,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] instruction_word,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_error
);

  cpu_state_e  cur_state, next_state;
  logic [31:0] ir;
  logic        ir_load;
  logic        load_done;
  logic        timeout;

  bus_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .busy        (mem_read | mem_write),
    .waitrequest (waitrequest),
    .timeout     (timeout),
    .bus_error   (bus_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= FETCH;
      ir         <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      cur_state  <= next_state;
      load_valid <= load_done;
      if (ir_load)   ir        <= readdata;
      if (load_done) load_data <= readdata;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state     = cur_state;
    state          = PHASE_FETCH;
    stall          = 1'b0;
    mem_address    = pc_addr;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = BE_WORD;
    ir_load        = 1'b0;
    load_done      = 1'b0;

    unique case (cur_state)
      FETCH: begin
        mem_read = active;
        stall    = waitrequest;
        if (!active) begin
          next_state = HALT;
        end else if (!waitrequest) begin
          next_state = EXEC;
          ir_load    = 1'b1;
        end else if (timeout) begin
          next_state = HALT;
        end
      end
      EXEC: begin
        state       = PHASE_EXEC;
        mem_address = data_addr;
        // A load wins when the decoder flags both.
        if (is_load) begin
          mem_read = 1'b1;
        end else if (is_store) begin
          mem_write      = 1'b1;
          mem_writedata  = store_data;
          mem_byteenable = store_be;
        end
        if (!(is_load || is_store)) begin
          next_state = FETCH;
        end else if (!waitrequest) begin
          next_state = FETCH;
          load_done  = is_load;
        end else begin
          stall = 1'b1;
          if (timeout) next_state = HALT;
        end
      end
      HALT: begin
        stall = 1'b1;
      end
      default: begin
        next_state = HALT;
        stall      = 1'b1;
      end
    endcase

    // Reset abandons any access in flight without waiting for a clock edge.
    if (reset) begin
      state       = PHASE_FETCH;
      stall       = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = pc_addr;
      ir_load     = 1'b0;
      load_done   = 1'b0;
    end
  end

  assign instruction_word = ir_load ? readdata : ir;

endmodule
